// File: rtl/eeg_pea_eng_pe_feed_if.sv
`default_nettype none
// ============================================================================
// Module      : eeg_pea_eng_pe_feed_if
// Description : PE DIN stream (activation/weight beat with valid/ready).
// Revision    : 1.0  initial release
// ============================================================================
interface eeg_pea_eng_pe_feed_if #(
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3
) ();
    logic                   DIN_VLD;
    logic                   DIN_RDY;
    logic                   ACT_LST;
    logic                   WEI_LST;
    logic [DATA_ACT_DW-1:0] ACT_DAT;
    logic [ARAM_ADD_AW-1:0] ACT_ADD;
    logic [DATA_WEI_DW-1:0] WEI_DAT;
    logic [CONV_WEI_DW-1:0] WEI_IDX;

    modport master (
        output DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX,
        input  DIN_RDY
    );

    modport slave (
        input  DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX,
        output DIN_RDY
    );
endinterface
`default_nettype wire

// File: rtl/eeg_pea_eng_pe_feed.sv
`default_nettype none
// ============================================================================
// Module      : eeg_pea_eng_pe_feed
// Description : Reads a run of activations from ARAM and streams every
//               (activation, weight tap) pair to one PE over valid/ready.
//               Optional macro FEED_ZERO_SKIP_EN drops zero activations.
// Revision    : 1.0  initial release
// ============================================================================
module eeg_pea_eng_pe_feed #(
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3,
    parameter int WEI_NUM     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           START,
    input  logic [ARAM_ADD_AW-1:0]         CFG_ACT_BASE,
    input  logic [ARAM_ADD_AW:0]           CFG_ACT_LEN,
    input  logic [CONV_WEI_DW-1:0]         CFG_CONV_WEI,
    input  logic [WEI_NUM*DATA_WEI_DW-1:0] CFG_WEI_VEC,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           ARAM_REN,
    output logic [ARAM_ADD_AW-1:0]         ARAM_ADD,
    input  logic [DATA_ACT_DW-1:0]         ARAM_DAT,
    eeg_pea_eng_pe_feed_if.master          din
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRIME = 2'd1;
    localparam logic [1:0] c_ST_FEED  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [ARAM_ADD_AW:0]   c_IDX_ONE  = (ARAM_ADD_AW+1)'(1);
    localparam logic [CONV_WEI_DW-1:0] c_TAP_ONE  = CONV_WEI_DW'(1);
    localparam logic [CONV_WEI_DW:0]   c_WEI_NUM  = (CONV_WEI_DW+1)'(WEI_NUM);
    localparam logic [CONV_WEI_DW-1:0] c_WEI_LAST = CONV_WEI_DW'(WEI_NUM-1);

    logic [1:0]                   r_state;
    logic [1:0]                   w_state_nxt;

    logic [ARAM_ADD_AW-1:0]       r_base;
    logic [ARAM_ADD_AW:0]         r_len;
    logic [CONV_WEI_DW-1:0]       r_tap_last;
    logic [WEI_NUM*DATA_WEI_DW-1:0] r_wei_vec;

    logic [ARAM_ADD_AW:0]         r_rd_idx;
    logic                         r_dv;
    logic [ARAM_ADD_AW:0]         r_dv_idx;

    logic                         r_pf_vld;
    logic [DATA_ACT_DW-1:0]       r_pf_dat;
    logic [ARAM_ADD_AW:0]         r_pf_idx;

    logic                         r_cur_vld;
    logic [DATA_ACT_DW-1:0]       r_cur_dat;
    logic [ARAM_ADD_AW:0]         r_cur_idx;
    logic [CONV_WEI_DW-1:0]       r_tap;

    logic [CONV_WEI_DW:0]         w_cw_ext;
    logic [CONV_WEI_DW-1:0]       w_tap_last_cfg;
    logic [ARAM_ADD_AW:0]         w_len_m1;
    logic                         w_fire;
    logic                         w_tap_end;
    logic                         w_cur_done;
    logic                         w_cur_last;
    logic                         w_keep;
    logic                         w_in_vld;
    logic                         w_run;
    logic [1:0]                   w_occ;
    logic                         w_issue;

    // Tap count 0 means one tap; anything above WEI_NUM saturates.
    always_comb begin
        w_cw_ext       = {1'b0, CFG_CONV_WEI};
        w_tap_last_cfg = '0;
        if (w_cw_ext == '0) begin
            w_tap_last_cfg = '0;
        end else if (w_cw_ext > c_WEI_NUM) begin
            w_tap_last_cfg = c_WEI_LAST;
        end else begin
            w_tap_last_cfg = CFG_CONV_WEI - c_TAP_ONE;
        end
    end

    assign w_len_m1   = r_len - c_IDX_ONE;
    assign w_fire     = r_cur_vld & din.DIN_RDY;
    assign w_tap_end  = (r_tap == r_tap_last);
    assign w_cur_done = w_fire & w_tap_end;
    assign w_cur_last = (r_cur_idx == w_len_m1);

`ifdef FEED_ZERO_SKIP_EN
    assign w_keep = (ARAM_DAT != '0) || (r_dv_idx == w_len_m1);
`else
    assign w_keep = 1'b1;
`endif
    assign w_in_vld = r_dv & w_keep;

    // A read is launched only when its data is certain to find a free slot
    // (current beat or prefetch) two edges later, even if the PE stalls.
    assign w_run   = (r_state == c_ST_PRIME) || (r_state == c_ST_FEED);
    assign w_occ   = 2'(r_cur_vld) + 2'(r_pf_vld) + 2'(r_dv) - 2'(w_cur_done);
    assign w_issue = w_run && (r_rd_idx < r_len) && (w_occ <= 2'd1);

    assign ARAM_REN = w_issue;
    assign ARAM_ADD = r_base + r_rd_idx[ARAM_ADD_AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        BUSY        = 1'b0;
        DONE        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (START) begin
                    w_state_nxt = (CFG_ACT_LEN == '0) ? c_ST_DONE : c_ST_PRIME;
                end
            end
            c_ST_PRIME: begin
                BUSY        = 1'b1;
                w_state_nxt = c_ST_FEED;
            end
            c_ST_FEED: begin
                BUSY = 1'b1;
                if (w_cur_done && w_cur_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                BUSY        = 1'b1;
                DONE        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_tap_last <= '0;
            r_wei_vec  <= '0;
            r_rd_idx   <= '0;
            r_dv       <= 1'b0;
            r_dv_idx   <= '0;
            r_pf_vld   <= 1'b0;
            r_pf_dat   <= '0;
            r_pf_idx   <= '0;
            r_cur_vld  <= 1'b0;
            r_cur_dat  <= '0;
            r_cur_idx  <= '0;
            r_tap      <= '0;
        end else if ((r_state == c_ST_IDLE) && START) begin
            r_base     <= CFG_ACT_BASE;
            r_len      <= CFG_ACT_LEN;
            r_tap_last <= w_tap_last_cfg;
            r_wei_vec  <= CFG_WEI_VEC;
            r_rd_idx   <= '0;
            r_dv       <= 1'b0;
            r_pf_vld   <= 1'b0;
            r_cur_vld  <= 1'b0;
            r_tap      <= '0;
        end else begin
            r_dv <= w_issue;
            if (w_issue) begin
                r_dv_idx <= r_rd_idx;
                r_rd_idx <= r_rd_idx + c_IDX_ONE;
            end

            if (r_cur_vld && !w_cur_done) begin
                if (w_fire) begin
                    r_tap <= r_tap + c_TAP_ONE;
                end
                if (w_in_vld) begin
                    r_pf_vld <= 1'b1;
                    r_pf_dat <= ARAM_DAT;
                    r_pf_idx <= r_dv_idx;
                end
            end else begin
                r_tap <= '0;
                // Prefetched activation is older than the one on the bus.
                if (r_pf_vld) begin
                    r_cur_vld <= 1'b1;
                    r_cur_dat <= r_pf_dat;
                    r_cur_idx <= r_pf_idx;
                    r_pf_vld  <= w_in_vld;
                    r_pf_dat  <= ARAM_DAT;
                    r_pf_idx  <= r_dv_idx;
                end else begin
                    r_cur_vld <= w_in_vld;
                    r_cur_dat <= ARAM_DAT;
                    r_cur_idx <= r_dv_idx;
                end
            end
        end
    end

    assign din.DIN_VLD = r_cur_vld;
    assign din.ACT_LST = r_cur_vld & w_cur_last;
    assign din.WEI_LST = r_cur_vld & w_tap_end;
    assign din.ACT_DAT = r_cur_dat;
    assign din.ACT_ADD = r_cur_idx[ARAM_ADD_AW-1:0];
    assign din.WEI_DAT = r_wei_vec[int'(r_tap)*DATA_WEI_DW +: DATA_WEI_DW];
    assign din.WEI_IDX = r_tap;

endmodule
`default_nettype wire
